// File: rtl/grant_pkg.sv
// Phase encoding shared by the lease controller and the downstream grant FSM,
// plus a helper for deriving counter widths.
package grant_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REQUESTING = 2'd1,
      GRANT      = 2'd2,
      REVOKE     = 2'd3
   } phase_e;

   function automatic int max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lease_down_counter.sv
// Loadable saturating down-counter, time-shared between the lease and the
// revoke-handshake phases of grant_lease_ctrl.
module lease_down_counter #(
   parameter int W = 8
) (
   input  logic         i_ck,
   input  logic         i_arst,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   input  logic         i_decrement,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   // next count: load has priority, decrement stops at zero
   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_value;
      end else if (i_decrement && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // count register
   always_ff @(posedge i_ck or posedge i_arst) begin
      if (i_arst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;
   assign o_zero  = (count_q == '0);

endmodule

// File: rtl/grant_lease_ctrl.sv
// Drives the downstream request/grant/revoke FSM with single-cycle transition
// strobes, bounding both the lease and the revoke handshake.
module grant_lease_ctrl
   import grant_pkg::*;
#(
   parameter  int LEASE_CYCLES   = 256,
   parameter  int REVOKE_TIMEOUT = 64,
   localparam int CNT_W          = $clog2(max(LEASE_CYCLES, REVOKE_TIMEOUT) + 1)
) (
   input  logic             i_ck,
   input  logic             i_arst,
   input  logic             i_req,
   input  logic             i_arbGrant,
   input  logic             i_release,
   input  logic             i_revokeAck,
   input  logic             i_granted,
   output logic             o_transition1,
   output logic             o_transition2,
   output logic             o_transition3,
   output logic             o_transition4,
   output logic [CNT_W-1:0] o_leaseRemaining,
   output logic             o_leaseExpired,
   output logic             o_revokeTimeout,
   output logic             o_mismatch
);

   phase_e             state_q;
   phase_e             state_d;
   logic               was_leased_q;
   logic               mismatch_q;
   logic               mismatch_now_s;
   logic               cnt_load_s;
   logic [CNT_W-1:0]   cnt_value_s;
   logic               cnt_dec_s;
   logic [CNT_W-1:0]   cnt_s;
   logic               cnt_zero_s;

   // shadow phase register plus one-cycle history of LEASED for the grace window
   always_ff @(posedge i_ck or posedge i_arst) begin
      if (i_arst) begin
         state_q      <= IDLE;
         was_leased_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         was_leased_q <= (state_q == GRANT);
      end
   end

   // next phase, strobes and counter control
   always_comb begin
      state_d         = state_q;
      o_transition1   = 1'b0;
      o_transition2   = 1'b0;
      o_transition3   = 1'b0;
      o_transition4   = 1'b0;
      o_leaseExpired  = 1'b0;
      o_revokeTimeout = 1'b0;
      cnt_load_s      = 1'b0;
      cnt_value_s     = '0;
      case (state_q)
         IDLE: begin
            if (i_req) begin
               o_transition1 = 1'b1;
               state_d       = REQUESTING;
            end else begin
               state_d = IDLE;
            end
         end
         REQUESTING: begin
            // a dropped request cannot abort here; the lease is released once granted
            if (i_arbGrant) begin
               o_transition2 = 1'b1;
               state_d       = GRANT;
               cnt_load_s    = 1'b1;
               cnt_value_s   = CNT_W'(LEASE_CYCLES - 1);
            end else begin
               state_d = REQUESTING;
            end
         end
         GRANT: begin
            o_leaseExpired = cnt_zero_s;
            if (i_release || !i_req || cnt_zero_s) begin
               o_transition3 = 1'b1;
               state_d       = REVOKE;
               cnt_load_s    = 1'b1;
               cnt_value_s   = CNT_W'(REVOKE_TIMEOUT - 1);
            end else begin
               state_d = GRANT;
            end
         end
         REVOKE: begin
            if (i_revokeAck) begin
               o_transition4 = 1'b1;
               state_d       = IDLE;
            end else if (cnt_zero_s) begin
               o_transition4   = 1'b1;
               o_revokeTimeout = 1'b1;
               state_d         = IDLE;
            end else begin
               state_d = REVOKE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cnt_dec_s = ((state_q == GRANT) || (state_q == REVOKE)) && !cnt_load_s;

   lease_down_counter #(
      .W (CNT_W)
   ) u_counter (
      .i_ck        (i_ck),
      .i_arst      (i_arst),
      .i_load      (cnt_load_s),
      .i_value     (cnt_value_s),
      .i_decrement (cnt_dec_s),
      .o_count     (cnt_s),
      .o_zero      (cnt_zero_s)
   );

   assign o_leaseRemaining = (state_q == GRANT) ? cnt_s : '0;

   // grant must be seen from the second LEASED cycle on, and never before the lease
   assign mismatch_now_s = (was_leased_q && (state_q == GRANT) && !i_granted)
                         || (((state_q == IDLE) || (state_q == REQUESTING)) && i_granted);

   // sticky mismatch flag, cleared only by reset
   always_ff @(posedge i_ck or posedge i_arst) begin
      if (i_arst) begin
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= mismatch_q | mismatch_now_s;
      end
   end

   assign o_mismatch = mismatch_q | mismatch_now_s;

endmodule

// File: tb/tb_grant_lease_ctrl.sv
// Self-checking bench for grant_lease_ctrl: directed scenarios followed by
// randomized traffic, all compared against a phase/age reference model.
module tb_grant_lease_ctrl;

   localparam int L  = 4;
   localparam int R  = 3;
   localparam int CW = $clog2(((L > R) ? L : R) + 1);

   logic          i_ck = 1'b0;
   logic          i_arst;
   logic          i_req;
   logic          i_arbGrant;
   logic          i_release;
   logic          i_revokeAck;
   logic          i_granted;
   logic          o_transition1;
   logic          o_transition2;
   logic          o_transition3;
   logic          o_transition4;
   logic [CW-1:0] o_leaseRemaining;
   logic          o_leaseExpired;
   logic          o_revokeTimeout;
   logic          o_mismatch;

   int checks   = 0;
   int failures = 0;

   // reference model: phase index 0..3, cycles spent in the phase, sticky mismatch
   int phase = 0;
   int age   = 0;
   bit mm    = 1'b0;

   grant_lease_ctrl #(
      .LEASE_CYCLES   (L),
      .REVOKE_TIMEOUT (R)
   ) dut (
      .i_ck             (i_ck),
      .i_arst           (i_arst),
      .i_req            (i_req),
      .i_arbGrant       (i_arbGrant),
      .i_release        (i_release),
      .i_revokeAck      (i_revokeAck),
      .i_granted        (i_granted),
      .o_transition1    (o_transition1),
      .o_transition2    (o_transition2),
      .o_transition3    (o_transition3),
      .o_transition4    (o_transition4),
      .o_leaseRemaining (o_leaseRemaining),
      .o_leaseExpired   (o_leaseExpired),
      .o_revokeTimeout  (o_revokeTimeout),
      .o_mismatch       (o_mismatch)
   );

   always #5 i_ck = ~i_ck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, check outputs mid-cycle, advance the model at the edge.
   task automatic cycle(input logic req, input logic gnt, input logic rel,
                        input logic ack, input logic granted);
      logic [3:0] exp_t;
      int         exp_rem;
      logic       exp_exp;
      logic       exp_to;
      logic       now;
      i_req       = req;
      i_arbGrant  = gnt;
      i_release   = rel;
      i_revokeAck = ack;
      i_granted   = granted;
      @(negedge i_ck);
      exp_t   = 4'd0;
      exp_rem = 0;
      exp_exp = 1'b0;
      exp_to  = 1'b0;
      case (phase)
         0: if (req) exp_t[0] = 1'b1;
         1: if (gnt) exp_t[1] = 1'b1;
         2: begin
            exp_rem = L - 1 - age;
            exp_exp = (age == L - 1);
            if (rel || !req || exp_exp) exp_t[2] = 1'b1;
         end
         3: begin
            if (ack) exp_t[3] = 1'b1;
            else if (age == R - 1) begin
               exp_t[3] = 1'b1;
               exp_to   = 1'b1;
            end
         end
         default: ;
      endcase
      now = ((phase == 2) && (age >= 1) && !granted) || ((phase <= 1) && granted);
      chk("strobes", 32'({o_transition4, o_transition3, o_transition2, o_transition1}), 32'(exp_t));
      chk("leaseRemaining", 32'(o_leaseRemaining), 32'(exp_rem));
      chk("leaseExpired", 32'(o_leaseExpired), 32'(exp_exp));
      chk("revokeTimeout", 32'(o_revokeTimeout), 32'(exp_to));
      chk("mismatch", 32'(o_mismatch), 32'(mm | now));
      @(posedge i_ck);
      mm = mm | now;
      if (exp_t != 4'd0) begin
         phase = (phase + 1) % 4;
         age   = 0;
      end else begin
         age++;
      end
      #1;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      i_req       = 1'b0;
      i_arbGrant  = 1'b0;
      i_release   = 1'b0;
      i_revokeAck = 1'b0;
      i_granted   = 1'b0;
      i_arst      = 1'b1;
      #2;
      chk("rst_strobes", 32'({o_transition4, o_transition3, o_transition2, o_transition1}), 32'd0);
      chk("rst_remaining", 32'(o_leaseRemaining), 32'd0);
      chk("rst_flags", 32'({o_leaseExpired, o_revokeTimeout, o_mismatch}), 32'd0);
      i_arst = 1'b0;
      phase  = 0;
      age    = 0;
      mm     = 1'b0;
   endtask

   initial begin
      i_arst = 1'b1;
      i_req = 1'b0; i_arbGrant = 1'b0; i_release = 1'b0; i_revokeAck = 1'b0; i_granted = 1'b0;
      #2;
      @(posedge i_ck);
      #1;
      do_reset();

      // basic lease running to expiry, then acknowledged revoke
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lease_first_remaining", 32'(o_leaseRemaining), 32'd3);
      for (int i = 0; i < L; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // early release in the second LEASED cycle, then revoke timeout
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < R; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("timeout_back_idle", 32'(phase), 32'd0);

      // ack coinciding with the revoke counter reaching zero
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // downstream grant missing through the lease: sticky mismatch
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mismatch_set", 32'(o_mismatch), 32'd1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mismatch_sticky", 32'(o_mismatch), 32'd1);

      // async reset in the middle of a lease, then immediate new request
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();

      // grant indication while idle
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mismatch_idle", 32'(o_mismatch), 32'd1);
      do_reset();

      // randomized traffic with a mostly well-behaved downstream FSM
      for (int n = 0; n < 600; n++) begin
         logic g;
         if ($urandom_range(0, 149) == 0) do_reset();
         g = (phase == 2);
         if ($urandom_range(0, 79) == 0) g = ~g;
         cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/grant_lease_ctrl.md
Name: grant_lease_ctrl

Overview:
Upstream driver for the request/grant/revoke state machine. It converts client and arbiter events into the four single-cycle transition strobes that step the downstream FSM through IDLE -> REQUESTING -> GRANT -> REVOKE -> IDLE. It keeps a shadow copy of the phase and enforces a bounded lease and a bounded revoke handshake with down-counters. It also cross-checks the downstream grant indication.

Parameters:
LEASE_CYCLES, 256, number of cycles a grant is held before forced revoke; must be >= 1
REVOKE_TIMEOUT, 64, cycles to wait for i_revokeAck before forcing return to idle; must be >= 1
CNT_W, $clog2(max(LEASE_CYCLES,REVOKE_TIMEOUT)+1), localparam, counter width (not overridable)

Ports:
i_ck  input  1  clock, rising edge
i_arst  input  1  reset, asynchronous, active-high
i_req  input  1  client request, level
i_arbGrant  input  1  arbiter grant, single-cycle pulse
i_release  input  1  client voluntary release, pulse
i_revokeAck  input  1  client acknowledges revoke, pulse
i_granted  input  1  downstream FSM grant indicator (its GRANT-state output)
o_transition1  output  1  strobe IDLE->REQUESTING
o_transition2  output  1  strobe REQUESTING->GRANT
o_transition3  output  1  strobe GRANT->REVOKE
o_transition4  output  1  strobe REVOKE->IDLE
o_leaseRemaining  output  CNT_W  lease cycles left while LEASED, else 0
o_leaseExpired  output  1  pulse: lease counter reached 0
o_revokeTimeout  output  1  pulse: revoke forced by timeout
o_mismatch  output  1  sticky: shadow phase disagrees with i_granted

Behaviour:
- Reset (async, i_arst=1): shadow state IDLE, counter 0, all outputs 0, o_mismatch cleared. Reset mid-operation aborts the lease immediately with no strobes. Downstream FSM shares i_arst, so both return to idle together.
- Shadow states: IDLE, WAIT_GRANT, LEASED, REVOKING. Encoding matches the downstream FSM order (0..3).
- Transition strobes are combinational from the registered shadow state and current inputs. A strobe is high exactly in the cycle the shadow state leaves its phase, so the downstream FSM and the shadow register change on the same edge.
- Exactly one strobe is high per cycle, at most. All strobes are 0 in any cycle with no transition.
- IDLE: if i_req=1 -> o_transition1=1, next WAIT_GRANT.
- WAIT_GRANT: if i_arbGrant=1 -> o_transition2=1, next LEASED, counter loaded LEASE_CYCLES-1.
  - i_req dropping here is ignored, because the downstream FSM has no abort path. The lease is then released on the first LEASED cycle.
- LEASED: counter decrements by 1 per cycle.
  - Exit with o_transition3=1 when any of these holds in the same cycle: i_release=1, i_req=0, or counter==0.
  - o_leaseExpired=1 whenever counter==0 in LEASED, even if a release coincides.
  - On exit, next state is REVOKING and the counter is loaded REVOKE_TIMEOUT-1.
  - Lease length: with LEASE_CYCLES=L and no early release, o_transition3 occurs in the L-th LEASED cycle.
- REVOKING: counter decrements by 1 per cycle.
  - If i_revokeAck=1 -> o_transition4=1, next IDLE.
  - Else if counter==0 -> o_transition4=1, o_revokeTimeout=1, next IDLE.
  - Ack and zero in the same cycle: ack wins, o_revokeTimeout=0.
- Stray pulses (i_arbGrant outside WAIT_GRANT, i_release/i_revokeAck outside their phase) are ignored.
- o_leaseRemaining = counter while LEASED, else 0.
- Mismatch check: o_mismatch sets and holds until reset when either of these holds:
  - the shadow state was LEASED in the previous cycle and is still LEASED, and i_granted=0; or
  - the shadow state is IDLE or WAIT_GRANT and i_granted=1.
  - The one-cycle grace on LEASED entry covers the downstream register latency.
- No combinational path from i_granted to any strobe.

Decomposition:
- Package grant_pkg holds:
  - the shared phase enum (IDLE, REQUESTING, GRANT, REVOKE; logic [1:0]), used by both this block and the downstream FSM;
  - a max() helper function for the CNT_W derivation.
- Sub-module lease_down_counter, parameterised by width, with ports load/value/decrement/zero. Instantiated once and reused for both the lease and revoke phases.

Test Plan:
- Basic lease, LEASE_CYCLES=4: i_req=1, then i_arbGrant pulse -> t1 in cycle 0 and t2 on the grant cycle; o_leaseRemaining reads 3,2,1,0; t3 and o_leaseExpired in the 4th LEASED cycle; then i_revokeAck -> t4, state IDLE.
- Early release: i_release in the 2nd LEASED cycle -> t3 that cycle, o_leaseExpired=0, o_leaseRemaining drops to 0 next cycle.
- Revoke timeout, REVOKE_TIMEOUT=3, no ack -> t4 and o_revokeTimeout in the 3rd REVOKING cycle.
- Ack on the same cycle the revoke counter hits 0 -> t4=1, o_revokeTimeout=0.
- Mismatch: hold i_granted=0 through LEASED -> o_mismatch=1 from the 2nd LEASED cycle and stays set. Also drive i_granted=1 in IDLE -> o_mismatch=1.
- Async reset asserted mid-LEASED, between clock edges -> all outputs 0 immediately; after release with i_req=1 -> t1 on the first clock edge.
